// File: rtl/pc_fetch_unit.sv
// rtl/pc_fetch_unit.sv - program counter and next-PC stage with BOOT/RUN/STALL/HALT sequencer
// Optional build macro: FETCH_COUNT_EN adds the fetch_count output and counter.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          PC_WIDTH = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                stall,
  input  logic                halt,
  input  logic                branch_taken,
  input  logic [31:0]         imm_signed,
  input  logic                jump,
  input  logic [31:0]         jmp_signed,
  output logic [PC_WIDTH-1:0] pcOut,
  output logic [PC_WIDTH-1:0] pc_plus4,
  output logic                fetch_valid,
  output logic                halted,
  output logic                redirect,
  output logic [1:0]          state
`ifdef FETCH_COUNT_EN
  ,
  output logic [31:0]         fetch_count
`endif
);

  typedef enum logic [1:0] {
    S_BOOT  = 2'd0,
    S_RUN   = 2'd1,
    S_STALL = 2'd2,
    S_HALT  = 2'd3
  } state_t;

  // Reset address with the byte-offset bits cleared so fetches stay word-aligned.
  localparam logic [PC_WIDTH-1:0] RESET_PC_ALIGNED = {RESET_PC[PC_WIDTH-1:2], 2'b00};
  localparam logic [PC_WIDTH-1:0] PC_STEP = {{(PC_WIDTH-3){1'b0}}, 3'd4};

  state_t              state_q;
  logic [PC_WIDTH-1:0] pc_q;
  logic [PC_WIDTH-1:0] branch_target;
  logic [PC_WIDTH-1:0] jump_target;

  // Only the low bits of the decoder fields feed the target arithmetic.
  logic unused_bits;
  assign unused_bits = ^{imm_signed[31:PC_WIDTH-2], jmp_signed[31:26]};

  // Sequential address, branch target (word offset) and pseudo-absolute jump target.
  always_comb begin
    pc_plus4      = pc_q + PC_STEP;
    branch_target = pc_plus4 + {imm_signed[PC_WIDTH-3:0], 2'b00};
    jump_target   = {pc_plus4[PC_WIDTH-1:28], jmp_signed[25:0], 2'b00};
  end

  assign pcOut = pc_q;
  assign state = state_q;

  // Sequencer: updates state, PC and the registered status outputs together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_BOOT;
      pc_q        <= RESET_PC_ALIGNED;
      redirect    <= 1'b0;
      halted      <= 1'b0;
      fetch_valid <= 1'b0;
    end else begin
      redirect <= 1'b0;
      case (state_q)
        S_BOOT: begin
          state_q     <= S_RUN;
          fetch_valid <= 1'b1;
        end
        S_RUN: begin
          if (halt) begin
            state_q     <= S_HALT;
            halted      <= 1'b1;
            fetch_valid <= 1'b0;
          end else if (stall) begin
            state_q     <= S_STALL;
            fetch_valid <= 1'b0;
          end else if (jump) begin
            pc_q     <= jump_target;
            redirect <= 1'b1;
          end else if (branch_taken) begin
            pc_q     <= branch_target;
            redirect <= 1'b1;
          end else begin
            pc_q <= pc_plus4;
          end
        end
        S_STALL: begin
          if (halt) begin
            state_q <= S_HALT;
            halted  <= 1'b1;
          end else if (!stall) begin
            // Resume without moving the PC; controls are looked at in the RUN cycle.
            state_q     <= S_RUN;
            fetch_valid <= 1'b1;
          end
        end
        S_HALT: begin
          state_q <= S_HALT;
        end
        default: begin
          state_q     <= S_BOOT;
          fetch_valid <= 1'b0;
          halted      <= 1'b0;
        end
      endcase
    end
  end

`ifdef FETCH_COUNT_EN
  // Counts executed fetches: every RUN edge that is not turned into halt or stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_count <= 32'd0;
    end else if (state_q == S_RUN && !halt && !stall) begin
      fetch_count <= fetch_count + 32'd1;
    end
  end
`endif

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
Program-counter and next-PC stage. It sits directly upstream of the instruction memory/decoder and drives its pcOut address input. It consumes the decoder's imm_signed and jmp_signed fields, plus taken-branch, jump, stall and halt controls from the control path, and produces the word-aligned fetch address every cycle. It also runs a small BOOT/RUN/STALL/HALT state machine that qualifies each fetch.

Parameters:
RESET_PC, 32'h0000_0000, fetch address loaded on reset; bits [1:0] forced to 0 internally.
PC_WIDTH, 32, width of PC datapath; all arithmetic is modulo 2^PC_WIDTH.

Ports:
clk  input  1  rising-edge clock.
rst  input  1  synchronous, active-high reset.
stall  input  1  hold current PC; freezes the sequencer.
halt  input  1  enter HALT permanently; only rst exits.
branch_taken  input  1  redirect to the branch target this cycle.
imm_signed  input  32  sign-extended word offset from the decoder.
jump  input  1  redirect to the jump target this cycle.
jmp_signed  input  32  zero-extended 26-bit word index from the decoder; only [25:0] is used.
pcOut  output  32  current fetch address, word-aligned.
pc_plus4  output  32  pcOut + 4, combinational (link value).
fetch_valid  output  1  high when the instruction at pcOut is to be executed.
halted  output  1  high in HALT.
redirect  output  1  registered pulse, one cycle after a branch or jump is taken.
state  output  2  BOOT=0, RUN=1, STALL=2, HALT=3.

Behaviour:
- Reset (rst=1 at an edge):
  - pcOut=RESET_PC & ~3, state=BOOT, halted=0, redirect=0.
  - rst has priority over every other input.
- BOOT: fetch_valid=0, pcOut held; goes unconditionally to RUN on the next edge. The first valid fetch is at RESET_PC.
- RUN: fetch_valid=1. Next PC is chosen at each edge by this priority:
  1. halt=1: pcOut held, go to HALT.
  2. stall=1: pcOut held, go to STALL. branch_taken and jump are ignored.
  3. jump=1: pcOut={pc_plus4[31:28], jmp_signed[25:0], 2'b00}, redirect=1.
  4. branch_taken=1: pcOut=pc_plus4 + (imm_signed<<2), redirect=1.
  5. Otherwise: pcOut=pc_plus4.
- jump and branch_taken high together: jump wins.
- redirect is 0 in every cycle not following a taken jump or branch.
- STALL: fetch_valid=0, pcOut held.
  - halt=1 goes to HALT.
  - stall=0 returns to RUN with no PC change; redirect inputs are evaluated starting in that RUN cycle.
- HALT: fetch_valid=0, halted=1, pcOut frozen. All inputs except rst are ignored.
- Wrap-around: 32'hFFFF_FFFC + 4 = 32'h0000_0000, with no flag. Branch targets also wrap modulo 2^32.
- pcOut[1:0] is 0 in every cycle.
- Single-cycle latency: inputs sampled at edge N take effect on pcOut after edge N.
- Reset mid-STALL or mid-HALT: BOOT next cycle with pcOut=RESET_PC.

Optional Feature:
FETCH_COUNT_EN
- Defined:
  - Adds output fetch_count[31:0].
  - Cleared on rst; increments by 1 at every edge where state=RUN, halt=0 and stall=0 (one per executed fetch).
  - Wraps at 2^32.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- rst high 2 cycles, then low, RESET_PC=0 -> pcOut=0 with fetch_valid=0 (BOOT), then fetch_valid=1; pcOut sequence 0,4,8,12 over the following edges.
- At pcOut=8: branch_taken=1, imm_signed=32'hFFFF_FFFE -> next pcOut=4, redirect=1 for one cycle; then 8 again.
- At pcOut=0x20: jump=1 and branch_taken=1, jmp_signed=0x10 -> pcOut=0x40 (jump priority), redirect pulse.
- At pcOut=0x0C: stall for 2 cycles while branch_taken=1 -> pcOut stays 0x0C, fetch_valid=0, state=2; after stall drops, the branch is evaluated.
- halt=1 at pcOut=0x10, then jump=1 -> pcOut frozen at 0x10, halted=1 indefinitely; rst -> BOOT, pcOut=0.
- RESET_PC=32'hFFFF_FFF8 -> pcOut sequence FFFF_FFF8, FFFF_FFFC, 0000_0000. With FETCH_COUNT_EN defined, fetch_count=3 after those fetches.
